// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode, funct, state and mux-select encodings for the
//               multicycle MIPS control path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } statetype;

endpackage
`default_nettype wire

// File: rtl/mips_mc_ctrl_aludec.sv
`default_nettype none
// ============================================================================
// Module      : aludec
// Description : ALU operation decoder from the FSM's aluop and the funct field.
// Revision    : 1.0 - initial release
// ============================================================================
module aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                // Unknown funct codes resolve to AND rather than X.
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = 3'b000;
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Moore main-control FSM for the multicycle MIPS datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    statetype   r_state;
    statetype   w_next;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic [1:0] w_aluop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next = MEMWB;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_aluop    = ALUOP_ADD;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUSRCB_B;
        pcsrc      = PCSRC_ALURESULT;
        case (r_state)
            FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = ALUSRCB_FOUR;
            end
            DECODE:  alusrcb = ALUSRCB_IMMSH2;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                w_aluop  = ALUOP_SUB;
                w_branch = 1'b1;
                pcsrc    = PCSRC_ALUOUT;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            ADDIWB:  w_regwrite = 1'b1;
            JEX: begin
                w_pcwrite = 1'b1;
                pcsrc     = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    // Gating with reset_n keeps write strobes quiet the instant reset asserts.
    assign pcen     = reset_n & (w_pcwrite | (w_branch & zero));
    assign memwrite = reset_n & w_memwrite;
    assign irwrite  = reset_n & w_irwrite;
    assign regwrite = reset_n & w_regwrite;

    aludec u_aludec (
        .aluop      (w_aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
`default_nettype wire
